// File: rtl/oam_dma_engine_if.sv
// Bus bundle for the OAM DMA engine: IO register strobes, router source reads and OAM writes.
// The IO data byte is a tristate net and travels as a separate inout port.
interface oam_dma_engine_if;
  logic [15:0] ioreg_addr;
  logic        ioreg_we_l;
  logic        ioreg_re_l;
  logic [15:0] src_addr;
  logic        src_re_l;
  logic [7:0]  src_data;
  logic [15:0] oam_addr;
  logic [7:0]  oam_data;
  logic        oam_we_l;
  logic        dma_active;

  // System side: CPU IO bus plus memory router.
  modport master (
    output ioreg_addr, ioreg_we_l, ioreg_re_l, src_data,
    input  src_addr, src_re_l, oam_addr, oam_data, oam_we_l, dma_active
  );

  // DMA engine side.
  modport slave (
    input  ioreg_addr, ioreg_we_l, ioreg_re_l, src_data,
    output src_addr, src_re_l, oam_addr, oam_data, oam_we_l, dma_active
  );
endinterface

// File: rtl/oam_dma_engine.sv
// OAM DMA controller: a write of XX to the trigger register copies XX00..XX(NUM_BYTES-1)
// into FE00.., one read of READ_LATENCY cycles followed by one OAM write per byte.
module oam_dma_engine #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter int unsigned NUM_BYTES    = 160,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  oam_dma_engine_if.slave   bus,
  inout  wire  [7:0]        ioreg_data
);

  localparam int unsigned     LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [7:0]      LAST_IDX = 8'(NUM_BYTES - 1);
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(READ_LATENCY - 1);
  localparam logic [15:0]     OAM_BASE = 16'hFE00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       src_hi_q, src_hi_d;
  logic [7:0]       index_q, index_d;
  logic [7:0]       hold_q, hold_d;
  logic [LAT_W-1:0] lat_q, lat_d;

  logic [15:0]      src_addr_q, src_addr_d;
  logic             src_re_l_q, src_re_l_d;
  logic [15:0]      oam_addr_q, oam_addr_d;
  logic [7:0]       oam_data_q, oam_data_d;
  logic             oam_we_l_q, oam_we_l_d;
  logic             active_q, active_d;

  logic             trig_c;
  logic             rd_hit_c;

  // Echo RAM E0..FF aliases working RAM C0..DF.
  function automatic logic [7:0] eff_hi(input logic [7:0] hi);
    return (hi >= 8'hE0) ? (hi - 8'h20) : hi;
  endfunction

  assign trig_c   = !bus.ioreg_we_l && (bus.ioreg_addr == DMA_REG_ADDR);
  assign rd_hit_c = !bus.ioreg_re_l && (bus.ioreg_addr == DMA_REG_ADDR);

  // Readback shows the registered byte, so a same-cycle write is visible only next cycle.
  assign ioreg_data = rd_hit_c ? src_hi_q : 8'bz;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      src_hi_q   <= 8'h00;
      index_q    <= 8'h00;
      hold_q     <= 8'h00;
      lat_q      <= '0;
      src_addr_q <= 16'h0000;
      src_re_l_q <= 1'b1;
      oam_addr_q <= 16'h0000;
      oam_data_q <= 8'h00;
      oam_we_l_q <= 1'b1;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_hi_q   <= src_hi_d;
      index_q    <= index_d;
      hold_q     <= hold_d;
      lat_q      <= lat_d;
      src_addr_q <= src_addr_d;
      src_re_l_q <= src_re_l_d;
      oam_addr_q <= oam_addr_d;
      oam_data_q <= oam_data_d;
      oam_we_l_q <= oam_we_l_d;
      active_q   <= active_d;
    end
  end

  // Next-state logic; a trigger write overrides whatever byte is in flight.
  always_comb begin
    state_d  = state_q;
    src_hi_d = src_hi_q;
    index_d  = index_q;
    hold_d   = hold_q;
    lat_d    = lat_q;

    case (state_q)
      IDLE: ;
      START: begin
        index_d = 8'h00;
        lat_d   = '0;
        state_d = READ;
      end
      READ: begin
        if (lat_q == LAST_LAT) begin
          hold_d  = bus.src_data;
          lat_d   = '0;
          state_d = WRITE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      WRITE: begin
        if (index_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          index_d = index_q + 8'd1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (trig_c) begin
      src_hi_d = ioreg_data;
      index_d  = 8'h00;
      lat_d    = '0;
      state_d  = START;
    end
  end

  // Output decode from the next state so strobes line up with the state they belong to.
  always_comb begin
    active_d   = 1'b0;
    src_re_l_d = 1'b1;
    src_addr_d = 16'h0000;
    oam_we_l_d = 1'b1;
    oam_addr_d = 16'h0000;
    oam_data_d = 8'h00;

    case (state_d)
      START: active_d = 1'b1;
      READ: begin
        active_d   = 1'b1;
        src_re_l_d = 1'b0;
        src_addr_d = {eff_hi(src_hi_d), index_d};
      end
      WRITE: begin
        active_d   = 1'b1;
        oam_we_l_d = 1'b0;
        oam_addr_d = OAM_BASE + {8'h00, index_d};
        oam_data_d = hold_d;
      end
      default: ;
    endcase
  end

  assign bus.src_addr   = src_addr_q;
  assign bus.src_re_l   = src_re_l_q;
  assign bus.oam_addr   = oam_addr_q;
  assign bus.oam_data   = oam_data_q;
  assign bus.oam_we_l   = oam_we_l_q;
  assign bus.dma_active = active_q;

endmodule
